// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle control FSM and opcode decoder.
package ctrl_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    BRANCH = 3'd5,
    HALT   = 3'd6
  } state_e;
  localparam logic [2:0] ALUOP_BR = 3'b000;
  localparam logic [2:0] ALUOP_I  = 3'b001;
  localparam logic [2:0] ALUOP_LD = 3'b010;
  localparam logic [2:0] ALUOP_ST = 3'b011;
  localparam logic [2:0] ALUOP_R  = 3'b100;
  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;
  typedef enum logic [2:0] {CLS_R, CLS_I, CLS_LD, CLS_ST, CLS_BR, CLS_ILL} cls_e;
  typedef struct packed {
    cls_e       cls;
    logic [2:0] alu_op;
    logic       alu_src_b;
  } dec_t;
  localparam dec_t DEC_ILL = '{cls: CLS_ILL, alu_op: ALUOP_BR, alu_src_b: 1'b0};
endpackage

// File: rtl/opcode_class_dec.sv
// opcode_class_dec: maps an RV32I opcode to its instruction class, ALUop and B-operand select.
module opcode_class_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output dec_t       dec
);
  always_comb begin
    dec = DEC_ILL;
    case (opcode)
      OPC_R:   dec = '{cls: CLS_R,  alu_op: ALUOP_R,  alu_src_b: 1'b0};
      OPC_I:   dec = '{cls: CLS_I,  alu_op: ALUOP_I,  alu_src_b: 1'b1};
      OPC_LD:  dec = '{cls: CLS_LD, alu_op: ALUOP_LD, alu_src_b: 1'b1};
      OPC_ST:  dec = '{cls: CLS_ST, alu_op: ALUOP_ST, alu_src_b: 1'b1};
      OPC_BR:  dec = '{cls: CLS_BR, alu_op: ALUOP_BR, alu_src_b: 1'b0};
      default: dec = DEC_ILL;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM sequencing fetch/decode/execute/memory/writeback
// with req/ready memory handshakes, a wait-timeout halt and a sticky illegal-opcode flag.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int               WAIT_W   = 8,
  parameter logic [WAIT_W-1:0] WAIT_MAX = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic [2:0] alu_op,
  output logic       alu_src_b,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state_o
);
  state_e            state_q, state_d;
  dec_t              dec, dec_q, dec_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              alu_phase;
  opcode_class_dec u_dec (
    .opcode(opcode),
    .dec   (dec)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      dec_q     <= DEC_ILL;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      dec_q     <= dec_d;
      illegal_q <= illegal_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    dec_d     = dec_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH:  state_d = imem_ready ? DECODE : (wait_q == WAIT_MAX ? HALT : FETCH);
      DECODE: begin
        dec_d     = dec;
        illegal_d = illegal_q | (dec.cls == CLS_ILL);
        state_d   = dec.cls == CLS_ILL ? FETCH : dec.cls == CLS_BR ? BRANCH : EXEC;
      end
      EXEC:   state_d = (dec_q.cls == CLS_LD || dec_q.cls == CLS_ST) ? MEM : WB;
      MEM:    state_d = dmem_ready ? (dec_q.cls == CLS_LD ? WB : FETCH)
                                   : (wait_q == WAIT_MAX ? HALT : MEM);
      WB:     state_d = FETCH;
      BRANCH: state_d = FETCH;
      default: state_d = HALT;
    endcase
    wait_d = state_d != state_q ? '0
           : (state_q == FETCH || state_q == MEM) ? wait_q + 1'b1 : wait_q;
  end
  // Fetch request is gated by rst_n so it drops the moment reset asserts.
  assign imem_req  = rst_n && state_q == FETCH;
  assign ir_we     = imem_req && imem_ready;
  assign pc_we     = ir_we || (state_q == BRANCH && zero);
  assign pc_src    = state_q == BRANCH;
  assign dmem_req  = state_q == MEM;
  assign dmem_we   = dmem_req && dec_q.cls == CLS_ST;
  assign alu_phase = state_q == EXEC || state_q == MEM;
  assign alu_op    = alu_phase ? dec_q.alu_op : ALUOP_BR;
  assign alu_src_b = alu_phase && dec_q.alu_src_b;
  assign reg_we    = state_q == WB;
  assign wb_sel    = reg_we && dec_q.cls == CLS_LD;
  assign illegal   = illegal_q;
  assign bus_err   = state_q == HALT;
  assign state_o   = state_q;
endmodule
